// File: rtl/velocity_table_sequencer.sv
// Builds an 8-entry juggling velocity table: vy from a multiply, vx from one
// shared-divider request per throw height, with a per-request watchdog.
module velocity_table_sequencer #(
    parameter int g       = 12,
    parameter int s       = 20,
    parameter int TIMEOUT = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [10:0] distance_in,
    input  logic [14:0] frame_per_beat_in,
    output logic [31:0] div_dividend_out,
    output logic [31:0] div_divisor_out,
    output logic        div_valid_out,
    input  logic [31:0] div_quotient_in,
    input  logic        div_valid_in,
    input  logic        div_error_in,
    output logic [10:0] vx_out [7:0],
    output logic [20:0] vy_out [7:0],
    output logic        table_valid_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_reg;
    logic [2:0]    p_reg;
    logic [10:0]   dist_reg;
    logic [14:0]   fpb_reg;
    logic          error_reg;
    logic          stale_reg;
    logic [CW-1:0] wait_cnt_reg;
    logic [10:0]   vx_reg [1:7];
    logic [20:0]   vy_reg [1:7];

    logic [17:0] divisor_w;
    logic [31:0] dividend_w;
    logic [31:0] vy_prod_w;
    logic [20:0] vy_calc_w;
    logic [10:0] quot_sat_w;
    logic [10:0] vx_wdata_w;
    logic        start_ok_w;
    logic        in_issue_w;
    logic        div_zero_w;
    logic        result_hit_w;
    logic        timeout_hit_w;
    logic        vx_we_w;

    assign divisor_w  = 18'(p_reg) * 18'(fpb_reg);
    assign dividend_w = p_reg[0] ? {21'd0, dist_reg} : 32'(2 * s);
    assign vy_prod_w  = 32'(g) * {14'd0, divisor_w};
    assign vy_calc_w  = (p_reg == 3'd2) ? 21'd0 : vy_prod_w[21:1];
    assign quot_sat_w = (div_quotient_in > 32'd2047) ? 11'd2047 : div_quotient_in[10:0];

    assign start_ok_w = start_in && (state_reg == IDLE || state_reg == DONE);
    assign in_issue_w = (state_reg == ISSUE);
    assign div_zero_w = (divisor_w == 18'd0);
    // A result arriving while a timed-out request is still outstanding belongs to that request.
    assign result_hit_w  = (state_reg == WAIT) && div_valid_in && !stale_reg;
    assign timeout_hit_w = (state_reg == WAIT) && !result_hit_w && (wait_cnt_reg == CW'(TIMEOUT - 1));
    assign vx_we_w       = (in_issue_w && div_zero_w) || result_hit_w || timeout_hit_w;
    assign vx_wdata_w    = (result_hit_w && !div_error_in) ? quot_sat_w : 11'd0;

    assign div_valid_out    = in_issue_w && !div_zero_w;
    assign div_dividend_out = div_valid_out ? dividend_w : 32'd0;
    assign div_divisor_out  = div_valid_out ? {14'd0, divisor_w} : 32'd0;
    assign table_valid_out  = (state_reg == DONE);
    assign busy_out         = in_issue_w || (state_reg == WAIT);
    assign error_out        = error_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            p_reg        <= 3'd1;
            dist_reg     <= '0;
            fpb_reg      <= '0;
            error_reg    <= 1'b0;
            stale_reg    <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            if (div_valid_in && stale_reg)
                stale_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start_in) begin
                        dist_reg  <= distance_in;
                        fpb_reg   <= frame_per_beat_in;
                        error_reg <= 1'b0;
                        stale_reg <= 1'b0;
                        p_reg     <= 3'd1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= '0;
                    if (div_zero_w)
                        error_reg <= 1'b1;
                    else
                        state_reg <= WAIT;
                end
                default: begin
                    if (result_hit_w) begin
                        if (div_error_in)
                            error_reg <= 1'b1;
                    end else if (timeout_hit_w) begin
                        error_reg <= 1'b1;
                        stale_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
            endcase
            if (vx_we_w) begin
                if (p_reg == 3'd7) begin
                    state_reg <= DONE;
                end else begin
                    p_reg     <= p_reg + 3'd1;
                    state_reg <= ISSUE;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_entry
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    vx_reg[gi] <= '0;
                    vy_reg[gi] <= '0;
                end else if (start_ok_w) begin
                    vx_reg[gi] <= '0;
                    vy_reg[gi] <= '0;
                end else begin
                    if (in_issue_w && p_reg == 3'(gi))
                        vy_reg[gi] <= vy_calc_w;
                    if (vx_we_w && p_reg == 3'(gi))
                        vx_reg[gi] <= vx_wdata_w;
                end
            end
            assign vx_out[gi] = vx_reg[gi];
            assign vy_out[gi] = vy_reg[gi];
        end
    endgenerate

    assign vx_out[0] = '0;
    assign vy_out[0] = '0;

endmodule
